// File: rtl/timer_device_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_device_if
// Description : Word-addressed load/store bus between the bridge and the
//               countdown timer, plus the timer's interrupt request line.
//               Addr - word offset (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved)
//               WE   - store strobe, sampled on the rising clock edge
//               DIn  - store data
//               DOut - load data, combinational from Addr
//               IRQ  - interrupt request towards CP0 HWInt[2]
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_device_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    // Bridge / CPU side
    modport master (
        output Addr,
        output WE,
        output DIn,
        input  DOut,
        input  IRQ
    );

    // Timer side
    modport slave (
        input  Addr,
        input  WE,
        input  DIn,
        output DOut,
        output IRQ
    );
endinterface
`default_nettype wire

// File: rtl/timer_device.sv
`default_nettype none
// ============================================================================
// Module      : timer_device
// Description : Memory-mapped countdown timer with one-shot and auto-reload
//               modes driving a single interrupt line.
//               clk  - system clock, rising edge
//               rst  - asynchronous reset, active-high
//               bus  - timer_device_if.slave (Addr, WE, DIn, DOut, IRQ)
//               Register map (word offsets):
//                 0 CTRL   [0]=En [2:1]=Mode [3]=IM, upper bits read 0
//                 1 PRESET CNT_W bits, zero-extended on read
//                 2 COUNT  read-only
//                 3 reserved, reads 0
// Revision    : 1.0 - initial release
// ============================================================================
module timer_device #(
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] PRESET_RST = '0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    timer_device_if.slave bus
);

    localparam logic [1:0]       c_addr_ctrl   = 2'd0;
    localparam logic [1:0]       c_addr_preset = 2'd1;
    localparam logic [1:0]       c_addr_count  = 2'd2;
    localparam logic [1:0]       c_mode_reload = 2'b01;
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_en;
    logic [1:0]       r_mode;
    logic             r_im;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic             r_irq_flag;

    logic [31:0]      w_dout;
    logic             w_autoreload;

    // Mode 1x is deliberately folded into one-shot.
    assign w_autoreload = (r_mode == c_mode_reload);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_en       <= 1'b0;
            r_mode     <= 2'b00;
            r_im       <= 1'b0;
            r_preset   <= PRESET_RST;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_en) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_count <= r_preset;
                    r_state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!r_en) begin
                        r_state <= ST_IDLE;
                    end else if (r_count > c_one) begin
                        r_count <= r_count - c_one;
                    end else begin
                        // COUNT of 0 or 1 both terminate, so PRESET=0 acts as 1.
                        r_count    <= '0;
                        r_irq_flag <= 1'b1;
                        r_state    <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (w_autoreload) begin
                        r_irq_flag <= 1'b0;
                    end else begin
                        r_en <= 1'b0;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // CPU stores come after the FSM so they override its En clear
            // and its flag set at the same edge.
            if (bus.WE) begin
                case (bus.Addr)
                    c_addr_ctrl: begin
                        r_en       <= bus.DIn[0];
                        r_mode     <= bus.DIn[2:1];
                        r_im       <= bus.DIn[3];
                        r_irq_flag <= 1'b0;
                    end
                    c_addr_preset: begin
                        r_preset   <= bus.DIn[CNT_W-1:0];
                        r_irq_flag <= 1'b0;
                    end
                    default: begin
                        // COUNT and the reserved offset ignore stores.
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_dout = 32'd0;
        case (bus.Addr)
            c_addr_ctrl:   w_dout = {28'd0, r_im, r_mode, r_en};
            c_addr_preset: w_dout = 32'(r_preset);
            c_addr_count:  w_dout = 32'(r_count);
            default:       w_dout = 32'd0;
        endcase
    end

    assign bus.DOut = w_dout;
    // IM gates only the output; the flag itself still sets while masked.
    assign bus.IRQ  = r_irq_flag & r_im;

endmodule
`default_nettype wire

// File: tb/tb_timer_device.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_device
// Description : Directed self-checking bench for timer_device. Expected
//               values are queued when stimulus is applied and consumed when
//               the corresponding DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_device;

    localparam logic [31:0] c_preset_rst = 32'h0000_00A5;

    logic clk;
    logic rst;

    timer_device_if bus ();

    timer_device #(
        .CNT_W      (32),
        .PRESET_RST (c_preset_rst)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic exp_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        bus.Addr = a;
        bus.WE   = 1'b1;
        bus.DIn  = d;
        @(posedge clk);
        #1;
        bus.WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.Addr = a;
        #1;
        d = bus.DOut;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] v);
        logic [31:0] d;
        exp_push(tag, v);
        rd(a, d);
        sb_check(d);
    endtask

    task automatic chk_irq(input string tag, input logic v);
        exp_push(tag, {31'd0, v});
        sb_check({31'd0, bus.IRQ});
    endtask

    initial begin
        logic [31:0] d;

        bus.Addr = 2'd0;
        bus.WE   = 1'b0;
        bus.DIn  = 32'd0;
        rst      = 1'b1;

        // Reset values
        #3;
        chk_irq("rst_irq", 1'b0);
        chk_rd("rst_ctrl", 2'd0, 32'd0);
        chk_rd("rst_preset", 2'd1, c_preset_rst);
        chk_rd("rst_count", 2'd2, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(5);
        chk_rd("idle_ctrl", 2'd0, 32'd0);
        chk_rd("idle_count", 2'd2, 32'd0);
        chk_rd("idle_preset", 2'd1, c_preset_rst);
        chk_irq("idle_irq", 1'b0);

        // One-shot, PRESET=5: IRQ rises at edge 7 and holds
        cpu_write(2'd1, 32'd5);
        cpu_write(2'd0, 32'h9);
        for (int k = 2; k <= 7; k++) begin
            exp_push($sformatf("os_count_e%0d", k), 32'(7 - k));
            exp_push($sformatf("os_irq_e%0d", k), {31'd0, (k == 7)});
        end
        tick(2);
        for (int k = 2; k <= 7; k++) begin
            if (k > 2) tick();
            rd(2'd2, d);
            sb_check(d);
            sb_check({31'd0, bus.IRQ});
        end
        tick(3);
        chk_irq("os_irq_hold", 1'b1);
        chk_rd("os_ctrl_en_cleared", 2'd0, 32'h8);
        cpu_write(2'd0, 32'h9);
        chk_irq("os_irq_ack", 1'b0);
        cpu_write(2'd0, 32'h0);
        tick(4);

        // Auto-reload, PRESET=3: pulses at edges 5, 11, 17, 23
        cpu_write(2'd1, 32'd3);
        cpu_write(2'd0, 32'hB);
        for (int e = 1; e <= 24; e++) begin
            exp_push($sformatf("ar_irq_e%0d", e), {31'd0, (e >= 5 && ((e - 5) % 6) == 0)});
        end
        for (int e = 1; e <= 24; e++) begin
            tick();
            sb_check({31'd0, bus.IRQ});
        end
        cpu_write(2'd0, 32'h0);
        tick(4);

        // Masked one-shot, PRESET=2: FSM reaches INT (En auto-clears), IRQ stays low
        cpu_write(2'd1, 32'd2);
        cpu_write(2'd0, 32'h1);
        for (int e = 1; e <= 8; e++) exp_push($sformatf("mask_irq_e%0d", e), 32'd0);
        for (int e = 1; e <= 8; e++) begin
            tick();
            sb_check({31'd0, bus.IRQ});
        end
        chk_rd("mask_ctrl_en_cleared", 2'd0, 32'h0);
        chk_rd("mask_count", 2'd2, 32'd0);

        // En cleared mid-count freezes COUNT
        cpu_write(2'd1, 32'd10);
        cpu_write(2'd0, 32'h1);
        tick(4);
        chk_rd("freeze_count_before", 2'd2, 32'd8);
        cpu_write(2'd0, 32'h0);
        tick(3);
        chk_rd("freeze_count_after", 2'd2, 32'd7);
        tick(2);
        chk_rd("freeze_count_hold", 2'd2, 32'd7);

        // PRESET=0 behaves as 1: IRQ at edge 3
        cpu_write(2'd1, 32'd0);
        cpu_write(2'd0, 32'h9);
        tick(2);
        chk_irq("p0_irq_e2", 1'b0);
        tick();
        chk_irq("p0_irq_e3", 1'b1);

        // Stores to COUNT and the reserved offset are ignored
        cpu_write(2'd2, 32'h55);
        chk_rd("count_store_ignored", 2'd2, 32'd0);
        chk_irq("count_store_keeps_irq", 1'b1);
        cpu_write(2'd3, 32'hFF);
        chk_rd("rsvd_reads_zero", 2'd3, 32'd0);
        chk_irq("rsvd_store_keeps_irq", 1'b1);
        chk_rd("p0_preset", 2'd1, 32'd0);

        // CTRL store in the INT cycle keeps En=1
        cpu_write(2'd1, 32'd2);
        cpu_write(2'd0, 32'h9);
        tick(3);
        chk_irq("int_st_irq_e3", 1'b0);
        tick();
        chk_irq("int_st_irq_e4", 1'b1);
        cpu_write(2'd0, 32'h9);
        chk_rd("int_st_ctrl_kept", 2'd0, 32'h9);
        chk_irq("int_st_irq_cleared", 1'b0);
        tick(3);
        chk_irq("int_st_rerun_e3", 1'b0);
        tick();
        chk_irq("int_st_rerun_e4", 1'b1);

        // Async reset drops a held IRQ without a clock edge
        tick(3);
        chk_irq("held_before_rst", 1'b1);
        rst = 1'b1;
        #1;
        chk_irq("rst_drops_irq", 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-count returns everything to reset values
        cpu_write(2'd1, 32'd20);
        cpu_write(2'd0, 32'hB);
        tick(5);
        chk_rd("mid_count", 2'd2, 32'd17);
        rst = 1'b1;
        #1;
        chk_irq("mid_rst_irq", 1'b0);
        chk_rd("mid_rst_ctrl", 2'd0, 32'd0);
        chk_rd("mid_rst_preset", 2'd1, c_preset_rst);
        chk_rd("mid_rst_count", 2'd2, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(4);
        chk_rd("post_rst_count", 2'd2, 32'd0);
        chk_rd("post_rst_ctrl", 2'd0, 32'd0);
        chk_irq("post_rst_irq", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
